// File: rtl/apb_pkg.sv
// Shared types and constants for the APB register-bank slave.
package apb_pkg;

    localparam int APB_AW = 16;
    localparam int APB_DW = 32;

    // Byte offset of the control register from the window base.
    localparam int CTRL_OFS = 0;

    // Handshake FSM states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // The read-only status register always occupies the last word of the window.
    function automatic int STATUS_OFS_fn(input int num_regs);
        return (num_regs - 1) * 4;
    endfunction

endpackage

// File: rtl/apb_wait_counter.sv
// Wait-state down-counter: loaded at each setup phase, counted down during
// the access phase. The zero flag marks the cycle in which pready may rise.
module apb_wait_counter (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load_i,
    input  logic [3:0] load_val_i,
    input  logic       dec_i,
    output logic       zero_o
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    // Load has priority; decrement saturates at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != 4'd0)) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == 4'd0);

endmodule

// File: rtl/apb_slave_regbank.sv
// APB slave with CTRL / DATA / STATUS register window and programmable wait
// states taken from CTRL[3:0] at each setup phase.
module apb_slave_regbank
    import apb_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR  = 16'h1000,
    parameter int          NUM_REGS   = 8,
    parameter logic [3:0]  WAIT_RESET = 4'd2
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [APB_AW-1:0] paddr,
    input  logic [APB_DW-1:0] pwdata,
    output logic              pready,
    output logic [APB_DW-1:0] prdata,
    output logic              pslverr
);

    localparam int IW = $clog2(NUM_REGS);
    // CTRL plus the DATA registers are storage; STATUS is a separate counter.
    localparam int NW = NUM_REGS - 1;
    localparam logic [IW-1:0] CTRL_IDX   = IW'(CTRL_OFS / 4);
    localparam logic [IW-1:0] STATUS_IDX = IW'(STATUS_OFS_fn(NUM_REGS) / 4);

    state_t            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              err_q, err_d;
    logic              wr_q, wr_d;
    logic [APB_DW-1:0] regs_q [NW];
    logic [7:0]        status_q;

    logic [APB_AW-1:0] offset;
    logic              hit;
    logic              waitLoad;
    logic              waitDec;
    logic              waitZero;
    logic              commit;
    logic [APB_DW-1:0] rdSel;

    // Window decode on the live address; only latched during a setup phase.
    assign offset = paddr - BASE_ADDR;
    assign hit    = (paddr[1:0] == 2'b00) && (paddr >= BASE_ADDR) &&
                    (offset < APB_AW'(4 * NUM_REGS));

    apb_wait_counter u_wait (
        .clk_i      (pclk),
        .rst_i      (preset),
        .load_i     (waitLoad),
        .load_val_i (regs_q[CTRL_IDX][3:0]),
        .dec_i      (waitDec),
        .zero_o     (waitZero)
    );

    // Next-state logic: setup latches the access, access counts wait states.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        err_d    = err_q;
        wr_d     = wr_q;
        waitLoad = 1'b0;
        waitDec  = 1'b0;
        case (state_q)
            IDLE: begin
                // penable high here is a protocol slip; treat it as setup.
                if (psel) begin
                    state_d  = ACCESS;
                    idx_d    = offset[IW+1:2];
                    err_d    = !hit;
                    wr_d     = pwrite;
                    waitLoad = 1'b1;
                end
            end
            ACCESS: begin
                if (!psel) begin
                    state_d = IDLE;
                end else if (!waitZero) begin
                    waitDec = 1'b1;
                end else if (penable) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (psel && !penable) begin
                    state_d  = ACCESS;
                    idx_d    = offset[IW+1:2];
                    err_d    = !hit;
                    wr_d     = pwrite;
                    waitLoad = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM and latched-access registers; reset aborts any transfer in flight.
    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            err_q   <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            wr_q    <= wr_d;
        end
    end

    assign pready  = (state_q == ACCESS) && waitZero;
    assign pslverr = pready && err_q;
    assign commit  = pready && psel && penable;

    // Register bank: writes and the OKAY counter update only on a completing hit.
    always_ff @(posedge pclk) begin
        if (preset) begin
            for (int i = 0; i < NW; i++) begin
                regs_q[i] <= (IW'(i) == CTRL_IDX) ? {28'h0, WAIT_RESET} : '0;
            end
            status_q <= 8'h00;
        end else if (commit && !err_q) begin
            status_q <= status_q + 8'd1;
            if (wr_q) begin
                for (int i = 0; i < NW; i++) begin
                    if (idx_q == IW'(i)) begin
                        regs_q[i] <= pwdata;
                    end
                end
            end
        end
    end

    // Read mux over the latched index.
    always_comb begin
        rdSel = '0;
        if (idx_q == STATUS_IDX) begin
            rdSel = {24'h0, status_q};
        end else begin
            for (int i = 0; i < NW; i++) begin
                if (idx_q == IW'(i)) begin
                    rdSel = regs_q[i];
                end
            end
        end
    end

    assign prdata = (pready && !wr_q && !err_q) ? rdSel : '0;

endmodule

// File: tb/tb_apb_slave_regbank.sv
// Directed bench for apb_slave_regbank: reset values, wait-state timing,
// error decode, abort, mid-transfer reset, back-to-back and STATUS wrap.
module tb_apb_slave_regbank;
    import apb_pkg::*;

    logic        pclk = 1'b0;
    logic        preset;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [15:0] paddr;
    logic [31:0] pwdata;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  expStatus = 8'h00;
    int          expWait = 2;

    // 10-unit clock period.
    always #5 pclk = ~pclk;

    apb_slave_regbank #(
        .BASE_ADDR  (16'h1000),
        .NUM_REGS   (8),
        .WAIT_RESET (4'd2)
    ) dut (
        .pclk    (pclk),
        .preset  (preset),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .pready  (pready),
        .prdata  (prdata),
        .pslverr (pslverr)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyReset(input int cycles);
        @(negedge pclk);
        preset  = 1'b1;
        psel    = 1'b0;
        penable = 1'b0;
        repeat (cycles) @(negedge pclk);
        checkOutput("reset.pready", {31'b0, pready}, 32'h0);
        checkOutput("reset.pslverr", {31'b0, pslverr}, 32'h0);
        checkOutput("reset.prdata", prdata, 32'h0);
        preset    = 1'b0;
        expStatus = 8'h00;
        expWait   = 2;
    endtask

    task automatic apbIdle();
        @(negedge pclk);
        psel    = 1'b0;
        penable = 1'b0;
    endtask

    // One transfer: setup, then access until pready (bounded), sampled at negedge.
    task automatic apbXfer(input logic wr, input logic [15:0] addr, input logic [31:0] wdata,
                           output logic [31:0] rdata, output logic err, output int waits);
        @(negedge pclk);
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = wdata;
        @(negedge pclk);
        penable = 1'b1;
        waits   = 0;
        while (pready !== 1'b1 && waits < 40) begin
            waits++;
            @(negedge pclk);
        end
        rdata = prdata;
        err   = pslverr;
    endtask

    task automatic applyStimulus(input string tag, input logic wr, input logic [15:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] expData,
                                 input logic expErr, input bit idleAfter);
        logic [31:0] rdata;
        logic        err;
        int          waits;
        apbXfer(wr, addr, wdata, rdata, err, waits);
        checkOutput({tag, ".waits"}, 32'(waits), 32'(expWait));
        checkOutput({tag, ".pslverr"}, {31'b0, err}, {31'b0, expErr});
        checkOutput({tag, ".prdata"}, rdata, expData);
        if (!expErr) expStatus = expStatus + 8'd1;
        if (idleAfter) apbIdle();
    endtask

    // Hard stop in case the DUT wedges somewhere the bounded loops do not cover.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        preset  = 1'b0;
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = 16'h0;
        pwdata  = 32'h0;

        // Reset defaults: CTRL reads back WAIT_RESET with two wait states.
        applyReset(2);
        applyStimulus("rst.ctrl", 1'b0, 16'h1000, 32'h0, 32'h00000002, 1'b0, 1'b1);

        // Write then read a data register, then STATUS counts both.
        applyReset(2);
        applyStimulus("wr.data1", 1'b1, 16'h1004, 32'hAAAAAAAA, 32'h0, 1'b0, 1'b1);
        applyStimulus("rd.data1", 1'b0, 16'h1004, 32'h0, 32'hAAAAAAAA, 1'b0, 1'b1);
        applyStimulus("rd.status", 1'b0, 16'h101C, 32'h0, 32'h00000002, 1'b0, 1'b1);

        // Wait-state sweep; the CTRL write itself still uses the old count.
        applyStimulus("wr.ctrl0", 1'b1, 16'h1000, 32'h0, 32'h0, 1'b0, 1'b1);
        expWait = 0;
        applyStimulus("rd.w0", 1'b0, 16'h1004, 32'h0, 32'hAAAAAAAA, 1'b0, 1'b1);
        applyStimulus("wr.ctrl5", 1'b1, 16'h1000, 32'h5, 32'h0, 1'b0, 1'b1);
        expWait = 5;
        applyStimulus("rd.w5", 1'b0, 16'h1000, 32'h0, 32'h00000005, 1'b0, 1'b1);

        // Error accesses: out of window, unaligned, just above and just below.
        applyStimulus("err.wr", 1'b1, 16'h20A0, 32'hBBBBBBBB, 32'h0, 1'b1, 1'b1);
        applyStimulus("err.unal", 1'b0, 16'h1002, 32'h0, 32'h0, 1'b1, 1'b1);
        applyStimulus("err.high", 1'b0, 16'h1020, 32'h0, 32'h0, 1'b1, 1'b1);
        applyStimulus("err.low", 1'b1, 16'h0FFC, 32'hBBBBBBBB, 32'h0, 1'b1, 1'b1);
        applyStimulus("err.keep", 1'b0, 16'h1004, 32'h0, 32'hAAAAAAAA, 1'b0, 1'b1);
        applyStimulus("err.status", 1'b0, 16'h101C, 32'h0, {24'h0, expStatus}, 1'b0, 1'b1);

        // STATUS is read-only but a write still completes OKAY.
        applyStimulus("wr.status", 1'b1, 16'h101C, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b1);
        applyStimulus("rd.status2", 1'b0, 16'h101C, 32'h0, {24'h0, expStatus}, 1'b0, 1'b1);

        // Abort: drop psel after two access cycles of a write.
        applyStimulus("wr.ctrl4", 1'b1, 16'h1000, 32'h4, 32'h0, 1'b0, 1'b1);
        expWait = 4;
        applyStimulus("wr.data2", 1'b1, 16'h1008, 32'h12345678, 32'h0, 1'b0, 1'b1);
        @(negedge pclk);
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 16'h1008;
        pwdata  = 32'hDEADBEEF;
        @(negedge pclk);
        penable = 1'b1;
        checkOutput("abort.acc1.pready", {31'b0, pready}, 32'h0);
        @(negedge pclk);
        checkOutput("abort.acc2.pready", {31'b0, pready}, 32'h0);
        @(negedge pclk);
        psel    = 1'b0;
        penable = 1'b0;
        @(negedge pclk);
        checkOutput("abort.state", 32'(dut.state_q), 32'(IDLE));
        checkOutput("abort.pready", {31'b0, pready}, 32'h0);
        applyStimulus("abort.keep", 1'b0, 16'h1008, 32'h0, 32'h12345678, 1'b0, 1'b1);
        applyStimulus("abort.status", 1'b0, 16'h101C, 32'h0, {24'h0, expStatus}, 1'b0, 1'b1);

        // Reset during a wait state of a read.
        @(negedge pclk);
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = 16'h1004;
        @(negedge pclk);
        penable = 1'b1;
        @(negedge pclk);
        preset  = 1'b1;
        @(negedge pclk);
        checkOutput("midrst.pready", {31'b0, pready}, 32'h0);
        checkOutput("midrst.state", 32'(dut.state_q), 32'(IDLE));
        checkOutput("midrst.prdata", prdata, 32'h0);
        preset    = 1'b0;
        psel      = 1'b0;
        penable   = 1'b0;
        expStatus = 8'h00;
        expWait   = 2;
        applyStimulus("midrst.ctrl", 1'b0, 16'h1000, 32'h0, 32'h00000002, 1'b0, 1'b1);
        applyStimulus("midrst.data1", 1'b0, 16'h1004, 32'h0, 32'h0, 1'b0, 1'b1);
        applyStimulus("midrst.data2", 1'b0, 16'h1008, 32'h0, 32'h0, 1'b0, 1'b1);
        applyStimulus("midrst.status", 1'b0, 16'h101C, 32'h0, 32'h00000003, 1'b0, 1'b1);

        // Back-to-back writes with setup issued in the DONE cycle.
        applyStimulus("b2b.ctrl0", 1'b1, 16'h1000, 32'h0, 32'h0, 1'b0, 1'b1);
        expWait = 0;
        applyStimulus("b2b.status0", 1'b0, 16'h101C, 32'h0, 32'h00000005, 1'b0, 1'b1);
        applyStimulus("b2b.wr1", 1'b1, 16'h100C, 32'h11111111, 32'h0, 1'b0, 1'b0);
        applyStimulus("b2b.wr2", 1'b1, 16'h1010, 32'h22222222, 32'h0, 1'b0, 1'b1);
        applyStimulus("b2b.status1", 1'b0, 16'h101C, 32'h0, 32'h00000008, 1'b0, 1'b1);
        applyStimulus("b2b.rd1", 1'b0, 16'h100C, 32'h0, 32'h11111111, 1'b0, 1'b0);
        applyStimulus("b2b.rd2", 1'b0, 16'h1010, 32'h0, 32'h22222222, 1'b0, 1'b1);

        // Fill STATUS up to 0xFF with back-to-back reads, then watch it wrap.
        while (expStatus != 8'hFF) begin
            applyStimulus("wrap.fill", 1'b0, 16'h100C, 32'h0, 32'h11111111, 1'b0, 1'b0);
        end
        apbIdle();
        applyStimulus("wrap.ff", 1'b0, 16'h101C, 32'h0, 32'h000000FF, 1'b0, 1'b1);
        applyStimulus("wrap.00", 1'b0, 16'h101C, 32'h0, 32'h00000000, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_slave_regbank.md
Name: apb_slave_regbank

Overview:
Synthesizable APB slave with a register bank and programmable wait states. It sits directly downstream of the team's APB master tasks and replaces the behavioural slave model in the APB bench. It decodes a 16-bit word-aligned address window and drives PREADY, PRDATA and PSLVERR. A transfer counter and a wait-state control register give the bench observable, deterministic timing.

Parameters:
BASE_ADDR, 16'h1000, first byte address of the register window
NUM_REGS, 8, number of 32-bit registers; power of 2, from 4 to 16
WAIT_RESET, 4'd2, reset value of the wait-state field CTRL[3:0]

Ports:
pclk  in  1  APB clock; all logic is on the rising edge
preset  in  1  reset, synchronous, active-high
psel  in  1  slave select
penable  in  1  access-phase indicator
pwrite  in  1  1 = write, 0 = read
paddr  in  16  byte address
pwdata  in  32  write data
pready  out  1  transfer-complete handshake
prdata  out  32  read data, valid only while pready=1 and pwrite=0
pslverr  out  1  error response, valid only while pready=1

Behaviour:
- Reset: the clock is pclk. The reset is preset, synchronous and active-high, sampled on the pclk rising edge. It has priority over everything else and may arrive mid-transfer.
  - State returns to IDLE.
  - pready, pslverr and prdata are 0 on the cycle after reset.
  - CTRL = {28'h0, WAIT_RESET}; data registers = 0; STATUS = 0.
  - A transfer in progress is aborted with no register write.
- Register map, as byte offsets from BASE_ADDR:
  - 0x00 CTRL: R/W. Bits [3:0] hold the wait count N. Bits [31:4] are writable storage.
  - 0x04 to (NUM_REGS-2)*4: DATA registers, R/W, 32 bits.
  - (NUM_REGS-1)*4 STATUS: read-only. Bits [7:0] count completed OKAY transfers and wrap 255 to 0. Other bits read 0. Writes to STATUS are ignored but still complete OKAY.
- Address decode: a hit requires paddr[1:0]==0 and BASE_ADDR <= paddr < BASE_ADDR + 4*NUM_REGS. Anything else is an error access.
- FSM states: IDLE, ACCESS, DONE.
  - IDLE: on psel=1 and penable=0 (setup cycle), latch the register index, the hit/error flag and pwrite. Load wcnt=CTRL[3:0], then go to ACCESS.
  - ACCESS: if psel=0, abort to IDLE. Otherwise, if wcnt!=0, decrement wcnt. If wcnt==0 and penable=1, the transfer completes this cycle and the next state is DONE.
  - DONE: a one-cycle turnaround. If psel=1 and penable=0 (back-to-back setup), perform the IDLE setup actions and go to ACCESS. Otherwise go to IDLE.
- Outputs:
  - pready = (state==ACCESS && wcnt==0). It is decoded from registers only, with no combinational path from the inputs.
  - Latency: pready rises in the (N+1)-th access cycle, i.e. N wait states. N=0 gives a zero-wait-state transfer. N=15 is the maximum.
  - pslverr = pready && latched error flag.
  - prdata = selected register when pready=1 and the transfer is a read hit; otherwise 0.
- Commit rules, applied at the edge where psel && penable && pready:
  - Write hit: the target register takes pwdata.
  - Error access: no register changes and STATUS does not increment.
  - OKAY transfer (read or write hit): STATUS[7:0] increments by 1.
- CTRL write timing: a CTRL write takes effect from the next setup phase. The wait count already loaded for the current transfer is unaffected.
- Abort: if psel drops before pready, there is no write and no STATUS increment, and the state goes to IDLE.
- Protocol violation: penable=1 with psel=1 while in IDLE is treated as a setup cycle, and the access is handled from there.

Decomposition:
- Package apb_pkg holds:
  - the state typedef (IDLE, ACCESS, DONE);
  - the offset constants CTRL_OFS=0 and STATUS_OFS_fn(NUM_REGS);
  - the width constants APB_AW=16 and APB_DW=32.
- One sub-module is natural: apb_wait_counter, which handles the 4-bit load/decrement and the zero flag. The FSM and register bank stay in the top module.

Test Plan:
- Reset default: hold preset for 2 cycles, then read 0x1000 → pready after exactly 2 wait states; prdata=0x00000002; pslverr=0.
- Write then read: write 0x1004=0xAAAAAAAA, then read 0x1004 → prdata=0xAAAAAAAA. Reading 0x101C afterwards → STATUS=0x00000002.
- Wait-state sweep: write CTRL=0 → the next read completes in the first access cycle. Write CTRL=5 → the next transfer has pready low for 5 access cycles and high on the 6th.
- Error access: write 0x20A0=0xBBBBBBBB, plus an unaligned read of 0x1002 → both return pslverr=1 and prdata=0. No register changes and STATUS is unchanged.
- Abort and reset:
  - With CTRL=4, drop psel after 2 access cycles of a write to 0x1008 → 0x1008 keeps its old value; the FSM is in IDLE on the next cycle.
  - Assert preset during a wait state → pready=0 next cycle and all registers are at their reset values.
- Back-to-back: with CTRL=0, issue two writes with the setup cycle immediately after DONE → both commit; STATUS increments by 2; STATUS wraps from 0xFF to 0x00 after 256 transfers.
